// File: rtl/hazard_unit_if.sv
// hazard_unit_if
//   Decode-stage hazard bundle. It carries the operand and destination
//   fields of the instruction in decode and the pipeline control inputs
//   toward hazard_unit. It carries the forwarding selects, the stall request
//   and the load-use statistics counter back.
//
//   master : decode / pipeline control side (drives dec_*, mem_busy, branch_flush)
//   slave  : hazard_unit (drives stall, alu_*_select, stall_count)
interface hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) ();

    logic                  dec_valid;
    logic [REG_ADDR_W-1:0] dec_top_addr;
    logic                  dec_top_used;
    logic [REG_ADDR_W-1:0] dec_bot_addr;
    logic                  dec_bot_used;
    logic [REG_ADDR_W-1:0] dec_dest_addr;
    logic                  dec_dest_wen;
    logic                  dec_is_load;
    logic                  mem_busy;
    logic                  branch_flush;

    logic                  stall;
    logic [4:0]            alu_top_select;
    logic [4:0]            alu_bot_select;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output dec_valid, dec_top_addr, dec_top_used, dec_bot_addr, dec_bot_used,
               dec_dest_addr, dec_dest_wen, dec_is_load, mem_busy, branch_flush,
        input  stall, alu_top_select, alu_bot_select, stall_count
    );

    modport slave (
        input  dec_valid, dec_top_addr, dec_top_used, dec_bot_addr, dec_bot_used,
               dec_dest_addr, dec_dest_wen, dec_is_load, mem_busy, branch_flush,
        output stall, alu_top_select, alu_bot_select, stall_count
    );

endinterface

// File: rtl/hazard_unit.sv
// hazard_unit
//   Decode-stage hazard detection and forwarding control. It tracks the
//   destinations of the instructions in EX, MEM and WB. It compares them with
//   the source operands of the instruction in decode and produces:
//     - alu_top_select / alu_bot_select : forwarding mux selects latched by
//       ID/EX (0 = register file, 1 = EX/MEM ALU result, 2 = MEM/WB result)
//     - stall       : hold IF/ID and load a bubble into ID/EX
//                     (load-use hazard or multi-cycle memory access)
//     - stall_count : saturating count of load-use stall cycles
//
//   Ports
//     clock  : system clock
//     nreset : synchronous, active-low reset
//     hu     : hazard_unit_if.slave bundle (decode fields in, controls out)
module hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic          clock,
    input  logic          nreset,
    hazard_unit_if.slave  hu
);

    localparam logic [4:0]       SEL_RF    = 5'd0;
    localparam logic [4:0]       SEL_EXMEM = 5'd1;
    localparam logic [4:0]       SEL_MEMWB = 5'd2;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest_addr;
        logic                  dest_wen;
        logic                  is_load;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '{
        valid:     1'b0,
        dest_addr: {REG_ADDR_W{1'b0}},
        dest_wen:  1'b0,
        is_load:   1'b0
    };

    // A tracked slot supplies an operand only if it really writes the same
    // register and the operand really reads the register file.
    function automatic logic slot_match(
        input slot_t                 s,
        input logic [REG_ADDR_W-1:0] addr,
        input logic                  used
    );
        return s.valid & s.dest_wen & used & (s.dest_addr == addr);
    endfunction

    // EX outranks MEM because it holds the youngest writer. A load in EX has
    // no result yet, so it never forwards. That case is the load-use stall,
    // which the caller resolves separately.
    function automatic logic [4:0] operand_select(
        input logic ex_hit,
        input logic ex_load,
        input logic mem_hit
    );
        logic [4:0] sel;
        if (ex_hit && !ex_load) begin
            sel = SEL_EXMEM;
        end else if (mem_hit) begin
            sel = SEL_MEMWB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    slot_t            ex_slot_r;
    slot_t            mem_slot_r;
    slot_t            wb_slot_r;
    slot_t            ex_fill_s;
    logic [CNT_W-1:0] stall_count_r;

    logic             top_ex_hit_s;
    logic             top_mem_hit_s;
    logic             bot_ex_hit_s;
    logic             bot_mem_hit_s;
    logic             load_use_s;
    logic             issue_s;
    logic             count_inc_s;
    logic             stall_s;
    logic [4:0]       top_select_s;
    logic [4:0]       bot_select_s;
    logic             wb_track_unused_s;

    // Operand-versus-slot comparisons for the instruction in decode.
    always_comb begin
        top_ex_hit_s  = slot_match(ex_slot_r,  hu.dec_top_addr, hu.dec_top_used);
        top_mem_hit_s = slot_match(mem_slot_r, hu.dec_top_addr, hu.dec_top_used);
        bot_ex_hit_s  = slot_match(ex_slot_r,  hu.dec_bot_addr, hu.dec_bot_used);
        bot_mem_hit_s = slot_match(mem_slot_r, hu.dec_bot_addr, hu.dec_bot_used);
    end

    // Load-use detection, stall request and counter-increment qualification.
    always_comb begin
        load_use_s  = hu.dec_valid & ex_slot_r.is_load & (top_ex_hit_s | bot_ex_hit_s);
        // A taken branch discards the decode instruction, so its hazard is moot.
        stall_s     = (load_use_s & ~hu.branch_flush) | hu.mem_busy;
        count_inc_s = load_use_s & ~hu.branch_flush & ~hu.mem_busy;
        issue_s     = hu.dec_valid & ~load_use_s & ~hu.branch_flush;
    end

    // Forwarding selects. A bubble or a stalled instruction gets plain register-file reads.
    always_comb begin
        top_select_s = SEL_RF;
        bot_select_s = SEL_RF;
        if (hu.dec_valid && !load_use_s) begin
            top_select_s = operand_select(top_ex_hit_s, ex_slot_r.is_load, top_mem_hit_s);
            bot_select_s = operand_select(bot_ex_hit_s, ex_slot_r.is_load, bot_mem_hit_s);
        end else begin
            top_select_s = SEL_RF;
            bot_select_s = SEL_RF;
        end
    end

    // Contents that enter the EX slot when the pipeline advances.
    always_comb begin
        ex_fill_s = SLOT_BUBBLE;
        if (issue_s) begin
            ex_fill_s.valid     = 1'b1;
            ex_fill_s.dest_addr = hu.dec_dest_addr;
            ex_fill_s.dest_wen  = hu.dec_dest_wen;
            ex_fill_s.is_load   = hu.dec_is_load;
        end else begin
            ex_fill_s = SLOT_BUBBLE;
        end
    end

    // Slot pipeline. A multi-cycle memory access freezes every stage.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            ex_slot_r  <= SLOT_BUBBLE;
            mem_slot_r <= SLOT_BUBBLE;
            wb_slot_r  <= SLOT_BUBBLE;
        end else if (hu.mem_busy) begin
            ex_slot_r  <= ex_slot_r;
            mem_slot_r <= mem_slot_r;
            wb_slot_r  <= wb_slot_r;
        end else begin
            ex_slot_r  <= ex_fill_s;
            mem_slot_r <= ex_slot_r;
            wb_slot_r  <= mem_slot_r;
        end
    end

    // Saturating load-use stall-cycle counter.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (count_inc_s && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    // The WB slot is tracked for pipeline visibility. The register file is
    // write-first, so no operand forwards from it. Likewise, a MEM-stage
    // load already has its data, so the MEM is_load flag never matters.
    assign wb_track_unused_s = ^{wb_slot_r, mem_slot_r.is_load};

    assign hu.stall          = stall_s;
    assign hu.alu_top_select = top_select_s;
    assign hu.alu_bot_select = bot_select_s;
    assign hu.stall_count    = stall_count_r;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    localparam int AW = 5;
    localparam int CW = 4;

    logic clock;
    logic nreset;

    hazard_unit_if #(.REG_ADDR_W(AW), .CNT_W(CW)) hu_if ();

    hazard_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clock  (clock),
        .nreset (nreset),
        .hu     (hu_if.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        string          tag;
        logic           stall;
        logic [4:0]     top;
        logic [4:0]     bot;
        logic [CW-1:0]  cnt;
    } exp_t;

    exp_t sb_q[$];
    int   total;
    int   bad;

    function automatic logic [CW-1:0] sat(input int v);
        return (v > 15) ? 4'd15 : v[CW-1:0];
    endfunction

    // Drive one decode cycle, queue its expectation, and check it at the falling edge.
    task automatic step(
        input string      tag,
        input logic       dv,
        input logic [4:0] ta, input logic tu,
        input logic [4:0] ba, input logic bu,
        input logic [4:0] da, input logic dw, input logic ld,
        input logic       busy, input logic fl,
        input logic       es, input logic [4:0] et, input logic [4:0] eb,
        input logic [CW-1:0] ec
    );
        exp_t e;
        hu_if.dec_valid     = dv;
        hu_if.dec_top_addr  = ta;
        hu_if.dec_top_used  = tu;
        hu_if.dec_bot_addr  = ba;
        hu_if.dec_bot_used  = bu;
        hu_if.dec_dest_addr = da;
        hu_if.dec_dest_wen  = dw;
        hu_if.dec_is_load   = ld;
        hu_if.mem_busy      = busy;
        hu_if.branch_flush  = fl;
        e.tag = tag; e.stall = es; e.top = et; e.bot = eb; e.cnt = ec;
        sb_q.push_back(e);
        @(negedge clock);
        e = sb_q.pop_front();
        total++;
        assert (hu_if.stall === e.stall) else begin
            bad++;
            $error("FAIL %s stall: got %0b expected %0b", e.tag, hu_if.stall, e.stall);
        end
        total++;
        assert (hu_if.alu_top_select === e.top) else begin
            bad++;
            $error("FAIL %s top_sel: got %0d expected %0d", e.tag, hu_if.alu_top_select, e.top);
        end
        total++;
        assert (hu_if.alu_bot_select === e.bot) else begin
            bad++;
            $error("FAIL %s bot_sel: got %0d expected %0d", e.tag, hu_if.alu_bot_select, e.bot);
        end
        total++;
        assert (hu_if.stall_count === e.cnt) else begin
            bad++;
            $error("FAIL %s stall_count: got %0d expected %0d", e.tag, hu_if.stall_count, e.cnt);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clock = 1'b0;
        nreset = 1'b0;
        hu_if.dec_valid = 1'b0;     hu_if.dec_top_addr = 5'd0; hu_if.dec_top_used = 1'b0;
        hu_if.dec_bot_addr = 5'd0;  hu_if.dec_bot_used = 1'b0; hu_if.dec_dest_addr = 5'd0;
        hu_if.dec_dest_wen = 1'b0;  hu_if.dec_is_load = 1'b0;  hu_if.mem_busy = 1'b0;
        hu_if.branch_flush = 1'b0;
        @(posedge clock);
        #1;

        // Reset state: stall follows mem_busy, selects 0, counter 0.
        step("rst_busy", 1'b0, 5'd0,1'b0, 5'd0,1'b0, 5'd0,1'b0,1'b0, 1'b1,1'b0, 1'b1, 5'd0, 5'd0, 4'd0);
        step("rst_idle", 1'b1, 5'd1,1'b1, 5'd2,1'b1, 5'd3,1'b1,1'b0, 1'b0,1'b0, 1'b0, 5'd0, 5'd0, 4'd0);
        nreset = 1'b1;

        // ALU back-to-back.
        step("b2b_wr",   1'b1, 5'd1,1'b1, 5'd2,1'b1, 5'd3,1'b1,1'b0, 1'b0,1'b0, 1'b0, 5'd0, 5'd0, 4'd0);
        step("b2b_rd",   1'b1, 5'd3,1'b1, 5'd3,1'b1, 5'd4,1'b1,1'b0, 1'b0,1'b0, 1'b0, 5'd1, 5'd1, 4'd0);
        // Gap of one instruction.
        step("gap_wr",   1'b1, 5'd1,1'b1, 5'd2,1'b1, 5'd5,1'b1,1'b0, 1'b0,1'b0, 1'b0, 5'd0, 5'd0, 4'd0);
        step("gap_mid",  1'b1, 5'd8,1'b1, 5'd9,1'b1, 5'd10,1'b1,1'b0, 1'b0,1'b0, 1'b0, 5'd0, 5'd0, 4'd0);
        step("gap_rd",   1'b1, 5'd11,1'b1, 5'd5,1'b1, 5'd12,1'b1,1'b0, 1'b0,1'b0, 1'b0, 5'd0, 5'd2, 4'd0);
        // Load-use.
        step("lu_load",  1'b1, 5'd13,1'b1, 5'd14,1'b1, 5'd7,1'b1,1'b1, 1'b0,1'b0, 1'b0, 5'd0, 5'd0, 4'd0);
        step("lu_stall", 1'b1, 5'd7,1'b1, 5'd15,1'b1, 5'd16,1'b1,1'b0, 1'b0,1'b0, 1'b1, 5'd0, 5'd0, 4'd0);
        step("lu_retry", 1'b1, 5'd7,1'b1, 5'd15,1'b1, 5'd16,1'b1,1'b0, 1'b0,1'b0, 1'b0, 5'd2, 5'd0, 4'd1);
        // Double writer, then dest_wen=0 and used=0.
        step("dw_a",     1'b1, 5'd1,1'b1, 5'd1,1'b1, 5'd2,1'b1,1'b0, 1'b0,1'b0, 1'b0, 5'd0, 5'd0, 4'd1);
        step("dw_b",     1'b1, 5'd1,1'b1, 5'd1,1'b1, 5'd2,1'b1,1'b0, 1'b0,1'b0, 1'b0, 5'd0, 5'd0, 4'd1);
        step("dw_rd",    1'b1, 5'd2,1'b1, 5'd2,1'b0, 5'd20,1'b0,1'b0, 1'b0,1'b0, 1'b0, 5'd1, 5'd0, 4'd1);
        step("nowen_rd", 1'b1, 5'd20,1'b1, 5'd2,1'b1, 5'd21,1'b1,1'b0, 1'b0,1'b0, 1'b0, 5'd0, 5'd2, 4'd1);
        // mem_busy for 3 cycles over a load-use.
        step("mb_load",  1'b1, 5'd0,1'b0, 5'd0,1'b0, 5'd9,1'b1,1'b1, 1'b0,1'b0, 1'b0, 5'd0, 5'd0, 4'd1);
        for (int i = 0; i < 3; i++) begin
            step("mb_busy", 1'b1, 5'd9,1'b1, 5'd9,1'b1, 5'd22,1'b1,1'b0, 1'b1,1'b0, 1'b1, 5'd0, 5'd0, 4'd1);
        end
        step("mb_lu",    1'b1, 5'd9,1'b1, 5'd9,1'b1, 5'd22,1'b1,1'b0, 1'b0,1'b0, 1'b1, 5'd0, 5'd0, 4'd1);
        step("mb_retry", 1'b1, 5'd9,1'b1, 5'd9,1'b1, 5'd22,1'b1,1'b0, 1'b0,1'b0, 1'b0, 5'd2, 5'd2, 4'd2);
        // Branch flush during load-use.
        step("fl_load",  1'b1, 5'd0,1'b0, 5'd0,1'b0, 5'd23,1'b1,1'b1, 1'b0,1'b0, 1'b0, 5'd0, 5'd0, 4'd2);
        step("fl_lu",    1'b1, 5'd23,1'b1, 5'd0,1'b0, 5'd24,1'b1,1'b0, 1'b0,1'b1, 1'b0, 5'd0, 5'd0, 4'd2);
        step("fl_next",  1'b1, 5'd23,1'b1, 5'd22,1'b1, 5'd24,1'b1,1'b0, 1'b0,1'b0, 1'b0, 5'd2, 5'd0, 4'd2);
        // mem_busy with flush: hold wins, EX is not replaced.
        step("bf_hold",  1'b1, 5'd24,1'b1, 5'd1,1'b1, 5'd30,1'b1,1'b0, 1'b1,1'b1, 1'b1, 5'd1, 5'd0, 4'd2);
        step("bf_flush", 1'b1, 5'd24,1'b1, 5'd1,1'b1, 5'd30,1'b1,1'b0, 1'b0,1'b1, 1'b0, 5'd1, 5'd0, 4'd2);
        // Reset mid-stream with a pending load-use.
        step("rs_load",  1'b1, 5'd0,1'b0, 5'd0,1'b0, 5'd25,1'b1,1'b1, 1'b0,1'b0, 1'b0, 5'd0, 5'd0, 4'd2);
        nreset = 1'b0;
        step("rs_edge",  1'b1, 5'd25,1'b1, 5'd0,1'b0, 5'd29,1'b1,1'b0, 1'b0,1'b0, 1'b1, 5'd0, 5'd0, 4'd2);
        nreset = 1'b1;
        step("rs_after", 1'b1, 5'd25,1'b1, 5'd0,1'b0, 5'd28,1'b1,1'b0, 1'b0,1'b0, 1'b0, 5'd0, 5'd0, 4'd0);
        // Drive the counter to all-ones and beyond.
        for (int k = 0; k < 17; k++) begin
            step("sat_load",  1'b1, 5'd0,1'b0, 5'd0,1'b0, 5'd26,1'b1,1'b1, 1'b0,1'b0, 1'b0, 5'd0, 5'd0, sat(k));
            step("sat_stall", 1'b1, 5'd26,1'b1, 5'd0,1'b0, 5'd27,1'b1,1'b0, 1'b0,1'b0, 1'b1, 5'd0, 5'd0, sat(k));
            step("sat_retry", 1'b1, 5'd26,1'b1, 5'd0,1'b0, 5'd27,1'b1,1'b0, 1'b0,1'b0, 1'b0, 5'd2, 5'd0, sat(k + 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Tracks the destination registers of the instructions in flight in the EX, MEM and WB stages and compares them against the operands of the instruction now in decode. From that comparison it produces the ALU operand-forwarding selects that the ID/EX register latches. It also detects load-use hazards and inserts a one-cycle bubble by raising `stall`, which holds IF/ID and zeroes the ID/EX register. It sits in the decode stage, directly upstream of ID/EX.

## Interface
Parameters
- `REG_ADDR_W`, 5, register-file address width (32 registers, all writable)
- `CNT_W`, 16, width of the stall-cycle statistics counter

Ports
- `clock`  in  1  system clock
- `nreset`  in  1  reset: nreset, synchronous, active-low; clock: clock
- `dec_valid`  in  1  decode holds a real instruction (0 = bubble)
- `dec_top_addr`  in  REG_ADDR_W  top operand source register
- `dec_top_used`  in  1  top operand reads the register file
- `dec_bot_addr`  in  REG_ADDR_W  bottom operand source register
- `dec_bot_used`  in  1  bottom operand reads the register file
- `dec_dest_addr`  in  REG_ADDR_W  destination register
- `dec_dest_wen`  in  1  instruction writes `dec_dest_addr`
- `dec_is_load`  in  1  result comes from memory (available only after MEM)
- `mem_busy`  in  1  memory stage multi-cycle access; freezes the pipeline
- `branch_flush`  in  1  taken branch; decode instruction is discarded
- `stall`  out  1  hold IF/ID, load bubble into ID/EX
- `alu_top_select`  out  5  top ALU mux select for ID/EX
- `alu_bot_select`  out  5  bottom ALU mux select for ID/EX
- `stall_count`  out  CNT_W  saturating count of load-use stall cycles

## Operation
- State: three slots, EX, MEM and WB. Each slot holds {valid, dest_addr, dest_wen, is_load}. A slot matches operand X when valid, dest_wen=1, dest_addr == X's address, and X's used flag is 1.
- Select codes:
  - 5'd0: register file (write-first; no WB forwarding needed)
  - 5'd1: forward EX/MEM ALU result
  - 5'd2: forward MEM/WB result
  - Codes 3–31 are never driven.
- Per operand, when `dec_valid` is 1:
  - EX slot matches and is not a load: select 1.
  - Otherwise, MEM slot matches: select 2.
  - Otherwise: select 0.
  - EX has priority over MEM, because EX holds the youngest writer.
- Load-use: if the EX slot matches either operand and `is_load` is 1, `stall`=1 and both selects are 0. After one bubble the load sits in MEM, so the retried instruction gets select 2.
- `stall` = load_use OR `mem_busy`. Selects are combinational from the decode inputs and the slots.
- Slot update per clock:
  - `mem_busy`=1: all slots hold.
  - Otherwise WB<=MEM and MEM<=EX. EX receives the decode fields when dec_valid=1, load_use=0 and branch_flush=0; in every other case EX is loaded invalid (bubble).
- Simultaneous events:
  - `branch_flush` with load_use: flush wins. `stall`=0 unless `mem_busy`=1, EX gets a bubble, and the counter does not increment.
  - `mem_busy` with `branch_flush`: hold wins. Nothing shifts, and the upstream keeps asserting flush until `mem_busy` drops.
  - `dec_valid`=0: selects 0, load_use 0.
- `stall_count` increments by 1 on each clock where load_use=1, branch_flush=0 and `mem_busy`=0. It saturates at all-ones and does not wrap.

## Timing
- Reset (nreset=0 at a clock edge): all slots invalid and `stall_count`=0 after that edge. With slots invalid, `stall`=`mem_busy` and the selects are 0. Reset mid-operation discards all in-flight tracking immediately.
- Decode to outputs: combinational, same cycle. ID/EX latches the selects on the next edge, and they are consumed in EX one cycle later.
- Slot latency: an instruction issued at edge N is in EX after N, in MEM after N+1, in WB after N+2, and drops out after N+3.
- A load-use stall lasts exactly 1 cycle when no `mem_busy` occurs. `mem_busy` extends any stall for its full duration.

## Test plan
- ALU back-to-back: issue `r3 <= r1+r2`, then `r4 <= r3+r3` on the next cycle. Required: both selects are 1 and `stall`=0.
- Gap of one instruction: writer r5, then an unrelated instruction, then a reader of r5 on the bottom operand. Required: `alu_bot_select`=2 and `alu_top_select`=0.
- Load-use: load r7, then a reader of r7 on the next cycle. Required: `stall`=1 for 1 cycle, EX bubble, then select 2 on the retry, and `stall_count` goes 0→1.
- Double writer: r2 written in both the EX and MEM slots. Required: select 1. Also check that `dest_wen`=0 or `used`=0 gives select 0.
- `mem_busy` held 3 cycles with a load in EX and a dependent instruction in decode. Required: `stall`=1 for all 3 cycles, slots frozen, counter unchanged, then the 1-cycle load stall, counter +1.
- `branch_flush` during load-use, then nreset=0 mid-stream. Required: `stall`=0 and no increment on the flush. After reset, selects are 0 and `stall_count`=0. Separately, preload the counter to all-ones and confirm a further stall leaves it at all-ones.
